// File: rtl/des_core_iter.sv
// des_core_iter: iterative DES engine, ROUNDS_PER_CYCLE Feistel rounds
// per clock, subkeys derived on the fly from the latched key.
module des_core_iter #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  if (!(ROUNDS_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_rpc_check
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [3:0] RC_STEP = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] RC_LAST = 4'(16 - ROUNDS_PER_CYCLE);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // S1..S8, each 4 rows of 16, row = {b1,b6}, column = b2..b5
  localparam logic [3:0] S_T [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++)
      y = {y[62:0], x[6'(64 - IP_T[6'(i)])]};
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++)
      y = {y[62:0], x[6'(64 - FP_T[6'(i)])]};
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++)
      y = {y[54:0], x[6'(64 - PC1_T[6'(i)])]};
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++)
      y = {y[46:0], x[6'(56 - PC2_T[6'(i)])]};
    return y;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++)
      y = {y[46:0], x[5'(32 - E_T[6'(i)])]};
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++)
      y = {y[30:0], x[5'(32 - P_T[5'(i)])]};
    return y;
  endfunction

  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    y = '0;
    for (int s = 0; s < 8; s++) begin
      six = 6'(x >> (42 - 6 * s));
      y = {y[27:0], S_T[{3'(s), six[5], six[0], six[4:1]}]};
    end
    return y;
  endfunction

  function automatic logic single_shift(input logic [4:0] n);
    return n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] l, r, l_nx, r_nx, f_out;
  logic [27:0] c, d, c_nx, d_nx;
  logic [47:0] k;
  logic [4:0]  n;
  logic [3:0]  rc;
  logic        mode;
  logic        accept;
  logic [63:0] ip_in;
  logic [55:0] pc1_in;

  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign ip_in    = perm_ip(in_data);
  assign pc1_in   = perm_pc1(in_key);

  // Unrolled chain of this cycle's rounds, subkeys derived as C/D rotate
  always_comb begin
    l_nx  = l;
    r_nx  = r;
    c_nx  = c;
    d_nx  = d;
    k     = '0;
    n     = '0;
    f_out = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      n = {1'b0, rc} + 5'(j) + 5'd1;
      if (mode) begin
        k    = perm_pc2({c_nx, d_nx});
        c_nx = rotr(c_nx, single_shift(5'd17 - n));
        d_nx = rotr(d_nx, single_shift(5'd17 - n));
      end else begin
        c_nx = rotl(c_nx, single_shift(n));
        d_nx = rotl(d_nx, single_shift(n));
        k    = perm_pc2({c_nx, d_nx});
      end
      f_out = l_nx ^ perm_p(sbox(expand(r_nx) ^ k));
      l_nx  = r_nx;
      r_nx  = f_out;
    end
  end

  // Control FSM with registered result; accept overrides the case outcome
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      rc        <= '0;
      mode      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          l  <= l_nx;
          r  <= r_nx;
          c  <= c_nx;
          d  <= d_nx;
          rc <= rc + RC_STEP;
          if (rc == RC_LAST) begin
            out_data  <= perm_fp({r_nx, l_nx});
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        l     <= ip_in[63:32];
        r     <= ip_in[31:0];
        c     <= pc1_in[55:28];
        d     <= pc1_in[27:0];
        rc    <= '0;
        mode  <= in_decrypt;
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_des_core_iter.sv
// tb_des_core_iter: known-answer, backpressure, reset and randomized
// checks of des_core_iter for every legal rounds-per-cycle setting.
module tb_des_core_iter;

  logic        clk;
  logic        rst;
  logic        dec;
  logic [63:0] din;
  logic [63:0] key;
  logic [4:0]  iv, ir, ov, ordy;
  logic [63:0] od [5];

  int n_chk;
  int n_err;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_core_iter #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_decrypt(dec),
      .in_data   (din),
      .in_key    (key),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int IP_Q[$] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  int FP_Q[$] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  int E_Q[$] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int P_Q[$] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int PC1_Q[$] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int PC2_Q[$] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SHIFT_Q[$] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int SB[$] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  function automatic logic [63:0] permute(input logic [63:0] v,
                                          input int inw, input int tbl[$]);
    logic [63:0] res, t;
    res = '0;
    foreach (tbl[i]) begin
      t   = v >> (inw - tbl[i]);
      res = {res[62:0], t[0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] rh,
                                          input logic [47:0] sk);
    logic [63:0] e, pv;
    logic [47:0] x;
    logic [31:0] so;
    int six, row, col;
    e  = permute({32'b0, rh}, 32, E_Q);
    x  = e[47:0] ^ sk;
    so = '0;
    for (int s = 0; s < 8; s++) begin
      six = int'((x >> (42 - 6 * s)) & 48'h3f);
      row = (six >> 5) * 2 + (six & 1);
      col = (six >> 1) & 15;
      so  = {so[27:0], 4'(SB[s * 64 + row * 16 + col])};
    end
    pv = permute({32'b0, so}, 32, P_Q);
    return pv[31:0];
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] k, x,
                                          input logic dm);
    logic [63:0] t;
    logic [27:0] c, d;
    logic [47:0] sub[$];
    logic [31:0] l, r, nr;
    t = permute(k, 64, PC1_Q);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      c = (c << SHIFT_Q[i]) | (c >> (28 - SHIFT_Q[i]));
      d = (d << SHIFT_Q[i]) | (d >> (28 - SHIFT_Q[i]));
      t = permute({8'b0, c, d}, 56, PC2_Q);
      sub.push_back(t[47:0]);
    end
    t = permute(x, 64, IP_Q);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      nr = l ^ feistel(r, sub[dm ? 15 - i : i]);
      l  = r;
      r  = nr;
    end
    return permute({r, l}, 64, FP_Q);
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one block to instance u; returns at #1 after out_valid rises.
  // lat counts edges with the accept edge as edge 1.
  task automatic run_block(input logic [2:0] u, input logic [63:0] k, x,
                           input logic dm, output logic [63:0] res,
                           output int lat);
    int w;
    din   = x;
    key   = k;
    dec   = dm;
    iv[u] = 1'b1;
    w = 0;
    while (!ir[u] && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready before accept", 64'(ir[u]), 64'd1);
    @(posedge clk); #1;
    iv[u] = 1'b0;
    lat = 1;
    while (!ov[u] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid arrival", 64'(ov[u]), 64'd1);
    res = od[u];
  endtask

  task automatic take(input logic [2:0] u);
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
    check("out_valid drop", 64'(ov[u]), 64'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res, back, k, x, pk;
    logic        dm;
    int          lat;
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    iv    = '0;
    ordy  = '0;
    dec   = 1'b0;
    din   = '0;
    key   = '0;
    @(posedge clk); #1;
    check("in_ready in reset", 64'(ir[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int p = 0; p < 5; p++) begin
      check("reset out_valid", 64'(ov[p]), 64'd0);
      check("reset out_data", od[p], 64'h0);
      check("reset in_ready", 64'(ir[p]), 64'd1);
    end

    for (int p = 0; p < 5; p++) begin
      run_block(3'(p), 64'h133457799BBCDFF1, 64'h0123456789ABCDEF,
                1'b0, res, lat);
      check("kat encrypt", res, 64'h85E813540F0AB405);
      check("kat latency", 64'(lat), 64'(1 + (16 >> p)));
      take(3'(p));
      run_block(3'(p), 64'h133457799BBCDFF1, 64'h85E813540F0AB405,
                1'b1, res, lat);
      check("kat decrypt", res, 64'h0123456789ABCDEF);
      take(3'(p));
    end

    for (int b = -1; b < 8; b++) begin
      pk = 64'h0E329232EA6D0D73;
      if (b >= 0) pk = pk ^ (64'h1 << (8 * b));
      run_block(3'd2, pk, 64'h8787878787878787, 1'b0, res, lat);
      check("parity key", res, 64'h0);
      take(3'd2);
    end

    run_block(3'd0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF,
              1'b0, res, lat);
    x     = 64'hDEADBEEF01234567;
    din   = x;
    iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp out_data", od[0], 64'h85E813540F0AB405);
      check("bp out_valid", 64'(ov[0]), 64'd1);
      check("bp in_ready", 64'(ir[0]), 64'd0);
    end
    ordy[0] = 1'b1;
    #1;
    check("bp release ready", 64'(ir[0]), 64'd1);
    @(posedge clk); #1;
    iv[0]   = 1'b0;
    ordy[0] = 1'b0;
    check("bp handoff valid", 64'(ov[0]), 64'd0);
    lat = 1;
    while (!ov[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 64'(lat), 64'd17);
    check("bp result", od[0], des_ref(64'h133457799BBCDFF1, x, 1'b0));
    take(3'd0);

    din   = 64'h0123456789ABCDEF;
    key   = 64'h133457799BBCDFF1;
    dec   = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #2;
    check("mid-run reset out_valid", 64'(ov[0]), 64'd0);
    check("mid-run reset out_data", od[0], 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 64'(ir[0]), 64'd1);
    @(posedge clk); #1;
    check("post-reset in_ready edge", 64'(ir[0]), 64'd1);
    check("post-reset out_valid", 64'(ov[0]), 64'd0);
    run_block(3'd0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF,
              1'b0, res, lat);
    check("post-reset encrypt", res, 64'h85E813540F0AB405);
    take(3'd0);

    for (int p = 0; p < 5; p++) begin
      ordy[p] = 1'b1;
      for (int t = 0; t < 1000; t++) begin
        k  = {$urandom, $urandom};
        x  = {$urandom, $urandom};
        dm = 1'($urandom_range(0, 1));
        run_block(3'(p), k, x, dm, res, lat);
        check("random block", res, des_ref(k, x, dm));
        if (!dm) begin
          run_block(3'(p), k, res, 1'b1, back, lat);
          check("round trip", back, x);
        end
      end
      @(posedge clk); #1;
      ordy[p] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/des_core_iter.md
# des_core_iter

Sequential, parametrised DES engine with encrypt/decrypt mode and a valid/ready interface, replacing the purely combinational 16-round datapath. It computes `ROUNDS_PER_CYCLE` Feistel rounds per clock. It generates subkeys on the fly from the 64-bit key, so the 16-subkey fan-out is not needed. It sits between the host-side block buffer and the output register stage of the DES subsystem; the existing subkey generator and permutation/S-box tables remain the functional golden model.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: Feistel rounds per clock; legal values 1, 2, 4, 8, 16; any other value is a elaboration error.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  block/key/mode present.
- `in_ready`  out  1  engine can accept a block this cycle.
- `in_decrypt`  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- `in_data`  in  64  plaintext/ciphertext; DES bit 1 = `in_data[63]`.
- `in_key`  in  64  DES key, bit 1 = `[63]`; parity bits 8,16,…,64 ignored.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  64  result, bit 1 = `[63]`.

## Operation
- State machine: `IDLE` → (accept) → `RUN` → (last round group done) → `DONE` → (`out_ready`) → `IDLE` or `RUN`.
- Accept condition: `in_valid && in_ready`.
- `in_ready` = (state==`IDLE`) or (state==`DONE` && `out_ready`). It is 0 while `rst` is high.
- On accept:
  - Register L/R = IP(`in_data`) split into halves.
  - Register C/D = PC1(`in_key`).
  - Latch the mode.
  - Clear the round counter `rc` (width 4) to 0.
- `RUN`, each cycle: apply rounds `rc+1` … `rc+ROUNDS_PER_CYCLE` back to back. Then `rc += ROUNDS_PER_CYCLE`.
- Round r: L' = R; R' = L xor P(S(E(R) xor K)).
  - Encrypt uses K = K_r.
  - Decrypt uses K = K_(17−r).
  - Shift schedule: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt: rotate C/D left by shift[r], then K = PC2(C,D).
  - Decrypt: K = PC2(C,D) first (round 1 uses the unrotated PC1 value, which equals K16). Then rotate C/D right by shift[17−r].
- After round 16: `out_data` = FP(R16 ‖ L16), the swap is undone before the final permutation. `rc` wraps to 0 and state goes to `DONE`.
- `DONE`: `out_data`/`out_valid` held stable until `out_ready`.
  - If `in_valid` is also high in the same cycle, the new block is accepted and state goes straight to `RUN`.
  - `out_valid` drops on the next edge either way.
- `in_valid` high while not ready: ignored. No buffering; the producer must hold its signals.
- Inputs are ignored during `RUN`; a mode or key change there does not affect the running block.
- S-box tables S1–S8 follow FIPS 46-3 exactly, each a distinct table.
- All data registers are 64/56 bits wide; no arithmetic beyond the 4-bit counter.

## Timing
- Reset values:
  - state `IDLE`
  - `out_valid` 0
  - `out_data` 64'h0
  - L, R, C, D, `rc` 0
  - mode 0
- Reset asserted mid-`RUN` or mid-`DONE`: the block is discarded, with no output, and the engine is ready on the first edge after `rst` falls.
- Latency, accept edge to `out_valid` high: 16/`ROUNDS_PER_CYCLE` + 1 edges, i.e. 17 for RPC=1, 2 for RPC=16.
- Throughput with `out_ready` tied high: one block per 16/`ROUNDS_PER_CYCLE` + 1 cycles. The back-to-back accept in `DONE` removes the `IDLE` bubble.
- `out_data` changes only on the edge that sets `out_valid`, or under reset.

## Test plan
- Encrypt with key 64'h133457799BBCDFF1, data 64'h0123456789ABCDEF. Required: `out_data` = 64'h85E813540F0AB405 with `out_valid` on edge 17 (RPC=1) and on edge 2 (RPC=16).
- Decrypt with the same key, data 64'h85E813540F0AB405. Required: 64'h0123456789ABCDEF.
- Encrypt with key 64'h0E329232EA6D0D73, data 64'h8787878787878787. Required: 64'h0000000000000000. Repeat with each key parity bit flipped; the result must be unchanged.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. Required: `out_data` stable, `in_ready`=0, and a new `in_valid` ignored. Then raise `out_ready` with `in_valid`=1. Required: the new block is accepted in that cycle and its result arrives 17 edges later.
- Reset: pulse `rst` during the 8th round of an encryption (RPC=1). Required: `out_valid`=0, `out_data`=0, and `in_ready`=1 after release. A following block produces the correct vector.
- Random regression: 1000 random key/data/mode triples for every legal `ROUNDS_PER_CYCLE`, checked against the combinational golden model. Each decrypt(encrypt(x)) must equal x.
